vip_yuv422_444: RTL and testbench
=================================

VIP_YUV422_444 -- requirements
Module: vip_yuv422_444

Interface
REQ-001 SHALL have parameter BITS, default 8, sample width of Y and chroma.
REQ-002 SHALL have parameter WIDTH, default 1280, nominal active pixels per line (even).
REQ-003 SHALL have parameter HEIGHT, default 960, nominal active lines per frame (informational only).
REQ-004 SHALL have port pclk  input  1  pixel clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; one clock, asynchronous active-low reset.
REQ-006 SHALL have port in_href  input  1  active-pixel qualifier; high for one contiguous run per line.
REQ-007 SHALL have port in_vsync  input  1  frame sync; passed through only.
REQ-008 SHALL have port in_y  input  BITS  luma of current pixel.
REQ-009 SHALL have port in_c  input  BITS  interleaved chroma: U on even in-line index, V on odd.
REQ-010 SHALL have ports out_href, out_vsync  output  1  in_href/in_vsync delayed by latency L.
REQ-011 SHALL have ports out_y, out_u, out_v  output  BITS  4:4:4 pixel for the YUV-to-RGB stage.

Function
REQ-012 SHALL keep an in-line pixel index: 0 on the first in_href-high cycle after in_href low, +1 each further in_href-high cycle.
REQ-013 SHALL treat pixels 2k and 2k+1 as pair k, with chroma Uk = in_c at index 2k and Vk = in_c at index 2k+1.
REQ-014 SHALL, with the macro in REQ-024 undefined, output both pixels of pair k with (Uk, Vk), with L = 2.
REQ-015 SHALL delay in_y, in_href and in_vsync by exactly L cycles, so that out_y is the luma of the pixel whose out_href is high.
REQ-016 SHALL, for a line with odd pixel count, output the final unpaired pixel with U = its own in_c and V = 2^(BITS-1).
REQ-017 SHALL drive out_y, out_u and out_v to 0 whenever out_href is low.
REQ-018 SHALL handle a one-cycle in_href gap between lines: the index restarts at 0 and no chroma is carried across lines.
REQ-019 SHALL support back-to-back lines, each of any length from 1 to WIDTH, with no stall or backpressure; input is accepted every in_href-high cycle.
REQ-020 SHALL not change the behaviour of any function in response to in_vsync.

Reset
REQ-021 SHALL, while rst_n is low, clear every register, including the index, delay lines and chroma holds, to 0.
REQ-022 SHALL hold all outputs at 0 while rst_n is low and during the first L cycles after release.
REQ-023 SHALL, when rst_n is asserted mid-line, discard the line; the first output afterwards is the pixel at index 0 of the next in_href run.

Configuration
REQ-024 SHALL, when macro VIP_CHROMA_INTERP_EN is defined, set L = 4 and give odd pixel 2k+1 chroma U = (Uk+Uk+1+1)>>1 and V = (Vk+Vk+1+1)>>1, computed at BITS+1 width.
REQ-025 SHALL, with VIP_CHROMA_INTERP_EN defined, give even pixels (Uk, Vk), and for the last pair of a line (no pair k+1) give the odd pixel (Uk, Vk).
REQ-026 SHALL, when VIP_CHROMA_INTERP_EN is undefined, contain no averaging logic, with L = 2.

Verification
REQ-027 SHALL cover reset: rst_n low with random inputs -> all outputs 0; first out_href exactly L cycles after the first in_href.
REQ-028 SHALL cover a basic line (no macro): BITS=8, line Y=10,20,30,40, C=100,200,50,60 -> outputs 2 cycles later are (10,100,200), (20,100,200), (30,50,60), (40,50,60), then zeros.
REQ-029 SHALL cover an odd-length line: Y=10,20,30, C=100,200,50 -> last output is (30,50,128).
REQ-030 SHALL cover interpolation (macro defined): the REQ-028 line -> outputs 4 cycles later (10,100,200), (20,75,130), (30,50,60), (40,50,60).
REQ-031 SHALL cover back-to-back lines: two 4-pixel lines with a 1-cycle href gap -> second line index 0 taken as U, and its chroma does not mix with the first line's.
REQ-032 SHALL cover reset mid-line: rst_n pulsed low at index 2 of 6 -> outputs 0, and the next line decodes correctly from index 0.

Source files
------------

// File: rtl/vip_yuv422_444.sv
// ============================================================================
// Module   : vip_yuv422_444
// Purpose  : YUV 4:2:2 (interleaved U/V) to 4:4:4 upsampler for the video path.
//            Optional macro VIP_CHROMA_INTERP_EN averages odd-pixel chroma.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vip_yuv422_444 #(
  parameter int BITS   = 8,
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 960
) (
  input  logic            pclk,
  input  logic            rst_n,
  input  logic            in_href,
  input  logic            in_vsync,
  input  logic [BITS-1:0] in_y,
  input  logic [BITS-1:0] in_c,
  output logic            out_href,
  output logic            out_vsync,
  output logic [BITS-1:0] out_y,
  output logic [BITS-1:0] out_u,
  output logic [BITS-1:0] out_v
);

  localparam int              c_IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [BITS-1:0] c_HALF  = {1'b1, {(BITS-1){1'b0}}};

  // HEIGHT only describes the frame; odd WIDTH/empty frames are not meaningful
  if (((WIDTH % 2) != 0) || (HEIGHT < 1)) begin : g_param_guard
  end

  // A run already in progress when reset releases is ignored until href drops
  logic               r_armed;
  logic               w_href;
  logic [c_IDX_W-1:0] w_idx;

  logic               r_s1_href;
  logic               r_s1_vsync;
  logic [c_IDX_W-1:0] r_s1_idx;
  logic [BITS-1:0]    r_s1_y;
  logic [BITS-1:0]    r_s1_c;

  assign w_href = in_href & r_armed;
  assign w_idx  = r_s1_href ? (r_s1_idx + c_IDX_W'(1)) : '0;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed    <= 1'b0;
      r_s1_href  <= 1'b0;
      r_s1_vsync <= 1'b0;
      r_s1_idx   <= '0;
      r_s1_y     <= '0;
      r_s1_c     <= '0;
    end else begin
      r_armed    <= r_armed | ~in_href;
      r_s1_href  <= w_href;
      r_s1_vsync <= in_vsync;
      r_s1_idx   <= w_href ? w_idx : '0;
      r_s1_y     <= in_y;
      r_s1_c     <= in_c;
    end
  end

`ifdef VIP_CHROMA_INTERP_EN
  logic            r_s2_href;
  logic            r_s2_vsync;
  logic            r_s2_odd;
  logic [BITS-1:0] r_s2_y;
  logic [BITS-1:0] r_s2_c;
  logic            r_s3_href;
  logic            r_s3_vsync;
  logic [BITS-1:0] r_s3_y;
  logic [BITS-1:0] r_s3_u;
  logic [BITS-1:0] r_s3_v;
  logic            w_pair_next;
  logic [BITS-1:0] w_u_avg;
  logic [BITS-1:0] w_v_avg;

  // With an odd pixel in stage 2: stage 3 holds its even partner, stage 1 and
  // the live input hold the following pair (if the line continues that far).
  assign w_pair_next = r_s1_href & w_href;
  assign w_u_avg = BITS'(((BITS+1)'(r_s3_u) + (BITS+1)'(r_s1_c) + (BITS+1)'(1)) >> 1);
  assign w_v_avg = BITS'(((BITS+1)'(r_s2_c) + (BITS+1)'(in_c) + (BITS+1)'(1)) >> 1);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_href  <= 1'b0;
      r_s2_vsync <= 1'b0;
      r_s2_odd   <= 1'b0;
      r_s2_y     <= '0;
      r_s2_c     <= '0;
      r_s3_href  <= 1'b0;
      r_s3_vsync <= 1'b0;
      r_s3_y     <= '0;
      r_s3_u     <= '0;
      r_s3_v     <= '0;
      out_href   <= 1'b0;
      out_vsync  <= 1'b0;
      out_y      <= '0;
      out_u      <= '0;
      out_v      <= '0;
    end else begin
      r_s2_href  <= r_s1_href;
      r_s2_vsync <= r_s1_vsync;
      r_s2_odd   <= r_s1_idx[0];
      r_s2_y     <= r_s1_y;
      r_s2_c     <= r_s1_c;
      r_s3_href  <= r_s2_href;
      r_s3_vsync <= r_s2_vsync;
      r_s3_y     <= r_s2_y;
      if (r_s2_odd) begin
        r_s3_u <= w_pair_next ? w_u_avg : r_s3_u;
        r_s3_v <= w_pair_next ? w_v_avg : r_s2_c;
      end else begin
        r_s3_u <= r_s2_c;
        r_s3_v <= r_s1_href ? r_s1_c : c_HALF;
      end
      out_href  <= r_s3_href;
      out_vsync <= r_s3_vsync;
      out_y     <= r_s3_href ? r_s3_y : '0;
      out_u     <= r_s3_href ? r_s3_u : '0;
      out_v     <= r_s3_href ? r_s3_v : '0;
    end
  end
`else
  logic [BITS-1:0] w_v_next;

  // V for an even pixel comes from the next input; none means unpaired pixel
  assign w_v_next = w_href ? in_c : c_HALF;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      out_href  <= 1'b0;
      out_vsync <= 1'b0;
      out_y     <= '0;
      out_u     <= '0;
      out_v     <= '0;
    end else begin
      out_href  <= r_s1_href;
      out_vsync <= r_s1_vsync;
      if (r_s1_href) begin
        out_y <= r_s1_y;
        // An odd pixel follows its even partner, whose U is still on out_u
        if (r_s1_idx[0]) begin
          out_u <= out_u;
          out_v <= r_s1_c;
        end else begin
          out_u <= r_s1_c;
          out_v <= w_v_next;
        end
      end else begin
        out_y <= '0;
        out_u <= '0;
        out_v <= '0;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_vip_yuv422_444.sv
// ============================================================================
// Module   : tb_vip_yuv422_444
// Purpose  : Directed, table-driven bench for the 4:2:2 to 4:4:4 upsampler.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vip_yuv422_444;

`ifdef VIP_CHROMA_INTERP_EN
  localparam int L = 4;
`else
  localparam int L = 2;
`endif
  localparam int NV = 22;
  localparam int NP = 14;

  logic       pclk     = 1'b0;
  logic       rst_n    = 1'b0;
  logic       in_href  = 1'b0;
  logic       in_vsync = 1'b0;
  logic [7:0] in_y     = 8'd0;
  logic [7:0] in_c     = 8'd0;
  logic       out_href;
  logic       out_vsync;
  logic [7:0] out_y;
  logic [7:0] out_u;
  logic [7:0] out_v;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic       href;
    logic       vsync;
    logic [7:0] y;
    logic [7:0] c;
    logic       eh;
    logic [7:0] ey;
    logic [7:0] eu;
    logic [7:0] ev;
  } vec_t;

  vec_t tbl [NV];

  vip_yuv422_444 #(.BITS(8), .WIDTH(16), .HEIGHT(4)) dut (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .in_href   (in_href),
    .in_vsync  (in_vsync),
    .in_y      (in_y),
    .in_c      (in_c),
    .out_href  (out_href),
    .out_vsync (out_vsync),
    .out_y     (out_y),
    .out_u     (out_u),
    .out_v     (out_v)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s row %0d: got %0d, expected %0d", name, idx, act, exp);
  endtask

  task automatic chk_all(input string tag, input int idx, input logic eh, input logic [7:0] ey,
                         input logic [7:0] eu, input logic [7:0] ev, input logic evs);
    chk({tag, ".href"},  idx, {7'd0, out_href},  {7'd0, eh});
    chk({tag, ".vsync"}, idx, {7'd0, out_vsync}, {7'd0, evs});
    chk({tag, ".y"},     idx, out_y, ey);
    chk({tag, ".u"},     idx, out_u, eu);
    chk({tag, ".v"},     idx, out_v, ev);
  endtask

  task automatic set_in(input int i, input logic h, input logic vs, input logic [7:0] y, input logic [7:0] c);
    tbl[i].href  = h;
    tbl[i].vsync = vs;
    tbl[i].y     = y;
    tbl[i].c     = c;
    tbl[i].eh    = 1'b0;
    tbl[i].ey    = 8'd0;
    tbl[i].eu    = 8'd0;
    tbl[i].ev    = 8'd0;
  endtask

  task automatic set_exp(input int i, input logic [7:0] y, input logic [7:0] u, input logic [7:0] v);
    tbl[i].eh = 1'b1;
    tbl[i].ey = y;
    tbl[i].eu = u;
    tbl[i].ev = v;
  endtask

  initial begin
    logic       evs;
    logic       ph [NP];
    logic [7:0] py [NP];
    logic [7:0] pc [NP];
    logic [7:0] ey2 [4];
    logic [7:0] eu2 [4];
    logic [7:0] ev2 [4];

    // Inputs: 4-pixel line, gap, 4-pixel line, gap, 3-pixel line, 1-pixel line
    for (int i = 0; i < NV; i++) set_in(i, 1'b0, 1'b0, 8'd0, 8'd0);
    set_in(0,  1'b0, 1'b1, 8'd0,  8'd0);
    set_in(1,  1'b1, 1'b1, 8'd10, 8'd100);
    set_in(2,  1'b1, 1'b0, 8'd20, 8'd200);
    set_in(3,  1'b1, 1'b0, 8'd30, 8'd50);
    set_in(4,  1'b1, 1'b0, 8'd40, 8'd60);
    set_in(5,  1'b0, 1'b0, 8'd99, 8'd77);
    set_in(6,  1'b1, 1'b0, 8'd11, 8'd101);
    set_in(7,  1'b1, 1'b0, 8'd21, 8'd201);
    set_in(8,  1'b1, 1'b0, 8'd31, 8'd51);
    set_in(9,  1'b1, 1'b0, 8'd41, 8'd61);
    set_in(10, 1'b0, 1'b0, 8'd99, 8'd77);
    set_in(11, 1'b1, 1'b0, 8'd10, 8'd100);
    set_in(12, 1'b1, 1'b0, 8'd20, 8'd200);
    set_in(13, 1'b1, 1'b0, 8'd30, 8'd50);
    set_in(14, 1'b0, 1'b0, 8'd99, 8'd77);
    set_in(16, 1'b1, 1'b0, 8'd7,  8'd9);
    set_in(17, 1'b0, 1'b1, 8'd0,  8'd0);

`ifdef VIP_CHROMA_INTERP_EN
    set_exp(5,  8'd10, 8'd100, 8'd200);
    set_exp(6,  8'd20, 8'd75,  8'd130);
    set_exp(7,  8'd30, 8'd50,  8'd60);
    set_exp(8,  8'd40, 8'd50,  8'd60);
    set_exp(10, 8'd11, 8'd101, 8'd201);
    set_exp(11, 8'd21, 8'd76,  8'd131);
    set_exp(12, 8'd31, 8'd51,  8'd61);
    set_exp(13, 8'd41, 8'd51,  8'd61);
    set_exp(15, 8'd10, 8'd100, 8'd200);
    set_exp(16, 8'd20, 8'd100, 8'd200);
    set_exp(17, 8'd30, 8'd50,  8'd128);
    set_exp(20, 8'd7,  8'd9,   8'd128);
    ey2 = '{8'd1,  8'd2,  8'd3,  8'd4};
    eu2 = '{8'd10, 8'd20, 8'd30, 8'd30};
    ev2 = '{8'd20, 8'd30, 8'd40, 8'd40};
`else
    set_exp(3,  8'd10, 8'd100, 8'd200);
    set_exp(4,  8'd20, 8'd100, 8'd200);
    set_exp(5,  8'd30, 8'd50,  8'd60);
    set_exp(6,  8'd40, 8'd50,  8'd60);
    set_exp(8,  8'd11, 8'd101, 8'd201);
    set_exp(9,  8'd21, 8'd101, 8'd201);
    set_exp(10, 8'd31, 8'd51,  8'd61);
    set_exp(11, 8'd41, 8'd51,  8'd61);
    set_exp(13, 8'd10, 8'd100, 8'd200);
    set_exp(14, 8'd20, 8'd100, 8'd200);
    set_exp(15, 8'd30, 8'd50,  8'd128);
    set_exp(18, 8'd7,  8'd9,   8'd128);
    ey2 = '{8'd1,  8'd2,  8'd3,  8'd4};
    eu2 = '{8'd10, 8'd10, 8'd30, 8'd30};
    ev2 = '{8'd20, 8'd20, 8'd40, 8'd40};
`endif

    // Reset held with random inputs: every output must stay 0
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk);
      in_href  = 1'($urandom);
      in_vsync = 1'($urandom);
      in_y     = 8'($urandom);
      in_c     = 8'($urandom);
      #1;
      chk_all("reset", i, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    end
    @(negedge pclk);
    rst_n    = 1'b1;
    in_href  = 1'b0;
    in_vsync = 1'b0;
    in_y     = 8'd0;
    in_c     = 8'd0;

    // Row i is sampled before its own inputs are driven
    for (int i = 0; i < NV; i++) begin
      @(negedge pclk);
      evs = 1'b0;
      if (i >= L) evs = tbl[i-L].vsync;
      chk_all("vec", i, tbl[i].eh, tbl[i].ey, tbl[i].eu, tbl[i].ev, evs);
      in_href  = tbl[i].href;
      in_vsync = tbl[i].vsync;
      in_y     = tbl[i].y;
      in_c     = tbl[i].c;
    end

    // Reset pulsed at index 2 of a 6-pixel line, then a fresh 4-pixel line
    @(negedge pclk);
    in_href = 1'b1; in_vsync = 1'b0; in_y = 8'd50; in_c = 8'd150;
    @(negedge pclk);
    in_y = 8'd51; in_c = 8'd151;
    @(negedge pclk);
    in_y = 8'd52; in_c = 8'd152;
    rst_n = 1'b0;
    #1;
    chk_all("rst_mid", 0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);

    for (int r = 0; r < NP; r++) begin
      ph[r] = 1'b0;
      py[r] = 8'd0;
      pc[r] = 8'd0;
    end
    for (int r = 0; r < 3; r++) begin
      ph[r] = 1'b1;
      py[r] = 8'(53 + r);
      pc[r] = 8'(153 + r);
    end
    for (int p = 0; p < 4; p++) begin
      ph[4+p] = 1'b1;
      py[4+p] = 8'(p + 1);
      pc[4+p] = 8'((p + 1) * 10);
    end

    for (int r = 0; r < NP; r++) begin
      logic       eh;
      logic [7:0] ey;
      logic [7:0] eu;
      logic [7:0] ev;
      @(negedge pclk);
      eh = 1'b0; ey = 8'd0; eu = 8'd0; ev = 8'd0;
      if ((r >= 4 + L) && (r < 8 + L)) begin
        eh = 1'b1;
        ey = ey2[r-4-L];
        eu = eu2[r-4-L];
        ev = ev2[r-4-L];
      end
      chk_all("post_rst", r, eh, ey, eu, ev, 1'b0);
      if (r == 0) rst_n = 1'b1;
      in_href = ph[r];
      in_y    = py[r];
      in_c    = pc[r];
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
